// File: rtl/dbg_hex_fmt.sv
// dbg_hex_fmt: formats a DATA_WIDTH-bit word as ASCII hex, most significant
// nibble first, optionally followed by CR LF. Bytes go out one per cycle on a
// wr/msg write port that connects straight to the debug queue, and the
// sequencer holds its place while the queue reports full.
//
// Build option: define DBG_HEX_FMT_PREFIX_EN to emit a lowercase "0x" in
// front of the digits (states PFX0/PFX1). Without it those states do not exist
// and IDLE goes straight to DIGIT.

module dbg_hex_fmt #(
    parameter int DATA_WIDTH = 32,
    parameter bit UPPERCASE  = 1'b1,
    parameter bit NEWLINE    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  full,
    output logic                  wr,
    output logic [7:0]            msg,
    output logic                  busy,
    output logic                  done
);

    localparam int            NDIG       = DATA_WIDTH / 4;
    localparam int            CW         = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG   = CW'(NDIG - 1);
    localparam logic [7:0]    ALPHA_BASE = UPPERCASE ? 8'h41 : 8'h61;

    if (DATA_WIDTH < 4 || (DATA_WIDTH % 4) != 0) begin : g_bad_width
        $error("dbg_hex_fmt: DATA_WIDTH must be a multiple of 4 and at least 4");
    end

`ifdef DBG_HEX_FMT_PREFIX_EN
    typedef enum logic [2:0] {S_IDLE, S_PFX0, S_PFX1, S_DIGIT, S_CR, S_LF} state_t;
    localparam state_t FIRST_STATE = S_PFX0;
`else
    typedef enum logic [2:0] {S_IDLE, S_DIGIT, S_CR, S_LF} state_t;
    localparam state_t FIRST_STATE = S_DIGIT;
`endif

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] value_q;
    logic [CW+1:0]         shamt;
    logic [3:0]            nibble;
    logic                  xfer;

    // A byte leaves on every emitting cycle the queue can take it; reset kills
    // the strobe immediately so an abandoned message never leaks a byte.
    assign wr   = (state != S_IDLE) && !full && !reset;
    assign xfer = wr;

    // Digit cnt sits (LAST_DIG - cnt) nibbles above bit 0 of the latched word.
    assign shamt  = {LAST_DIG - cnt, 2'b00};
    assign nibble = 4'(value_q >> shamt);

    // Map the current state (and nibble, in DIGIT) to the outgoing ASCII byte.
    always_comb begin
        // NOTE: default first so every path assigns msg and no latch is inferred.
        msg = 8'h00;
        case (state)
`ifdef DBG_HEX_FMT_PREFIX_EN
            S_PFX0:  msg = 8'h30;
            S_PFX1:  msg = 8'h78;
`endif
            S_DIGIT: msg = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                            : (ALPHA_BASE + {4'h0, nibble} - 8'd10);
            S_CR:    msg = 8'h0D;
            S_LF:    msg = 8'h0A;
            default: msg = 8'h00;
        endcase
    end

    // Sequence one message: latch on start, advance one state per transferred byte.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register updates from the values seen before the edge.
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            value_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        value_q <= value;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= FIRST_STATE;
                    end
                end
`ifdef DBG_HEX_FMT_PREFIX_EN
                S_PFX0: if (xfer) state <= S_PFX1;
                S_PFX1: if (xfer) state <= S_DIGIT;
`endif
                S_DIGIT: begin
                    if (xfer) begin
                        if (cnt == LAST_DIG) begin
                            if (NEWLINE) begin
                                state <= S_CR;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_CR: if (xfer) state <= S_LF;
                S_LF: begin
                    if (xfer) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_hex_fmt.sv
// Directed bench for dbg_hex_fmt. Three instances share clock, reset and full:
//   dut_a: defaults (32-bit, uppercase, CR LF)
//   dut_b: lowercase, no terminator
//   dut_c: 4-bit word (single digit, 1-bit counter)
// Expected byte streams are hand-written strings; with DBG_HEX_FMT_PREFIX_EN
// defined each expected message gains a leading "0x".

module tb_dbg_hex_fmt;

    logic        clk = 1'b0;
    logic        reset;
    logic        full;
    logic        start_a, start_b, start_c;
    logic [31:0] value_a, value_b;
    logic [3:0]  value_c;
    logic        wr_a, wr_b, wr_c;
    logic [7:0]  msg_a, msg_b, msg_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    // Observed writes (byte, cycle) and done-pulse cycles per instance.
    logic [7:0] lg_a[$], lg_b[$], lg_c[$];
    int         lc_a[$], lc_b[$], lc_c[$];
    int         ld_a[$], ld_b[$], ld_c[$];
    logic [7:0] exp_q[$];

    dbg_hex_fmt dut_a (
        .clk(clk), .reset(reset), .start(start_a), .value(value_a), .full(full),
        .wr(wr_a), .msg(msg_a), .busy(busy_a), .done(done_a)
    );

    dbg_hex_fmt #(.UPPERCASE(1'b0), .NEWLINE(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .value(value_b), .full(full),
        .wr(wr_b), .msg(msg_b), .busy(busy_b), .done(done_b)
    );

    dbg_hex_fmt #(.DATA_WIDTH(4)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .value(value_c), .full(full),
        .wr(wr_c), .msg(msg_c), .busy(busy_c), .done(done_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample outputs mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (wr_a === 1'b1) begin lg_a.push_back(msg_a); lc_a.push_back(cyc); end
        if (wr_b === 1'b1) begin lg_b.push_back(msg_b); lc_b.push_back(cyc); end
        if (wr_c === 1'b1) begin lg_c.push_back(msg_c); lc_c.push_back(cyc); end
        if (done_a === 1'b1) ld_a.push_back(cyc);
        if (done_b === 1'b1) ld_b.push_back(cyc);
        if (done_c === 1'b1) ld_c.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        lg_a.delete(); lc_a.delete(); ld_a.delete();
        lg_b.delete(); lc_b.delete(); ld_b.delete();
        lg_c.delete(); lc_c.delete(); ld_c.delete();
        exp_q.delete();
    endtask

    task automatic add_exp(input string s, input bit nl);
`ifdef DBG_HEX_FMT_PREFIX_EN
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h78);
`endif
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        if (nl) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    function automatic int q_first(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    function automatic int q_last(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -1;
    endfunction

    function automatic int done_count(input int sel);
        case (sel)
            0:       return ld_a.size();
            1:       return ld_b.size();
            default: return ld_c.size();
        endcase
    endfunction

    // Bounded wait for the n-th done pulse of an instance; ends mid-cycle.
    task automatic wait_done(input int sel, input int n, input int budget);
        int k = 0;
        while (done_count(sel) < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        total++;
        if (done_count(sel) < n) begin
            bad++;
            $display("FAIL wait_done[%0d]: done pulses=%0d required=%0d", sel, done_count(sel), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; full = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        value_a = '0; value_b = '0; value_c = '0;
        repeat (3) tick();
        total++; if (wr_a !== 1'b0)   begin bad++; $display("FAIL reset_wr: got %b want 0", wr_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_a); end
        reset = 1'b0;
        repeat (2) tick();
        total++; if (wr_a !== 1'b0)   begin bad++; $display("FAIL idle_wr: got %b want 0", wr_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy_a); end
    endtask

    task automatic test_basic();
        int c0;
        clear_logs();
        add_exp("1234ABCD", 1'b1);
        value_a = 32'h1234ABCD; start_a = 1'b1; c0 = cyc;
        tick();
        start_a = 1'b0;
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy_a); end
        wait_done(0, 1, 40);
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy_a); end
        repeat (3) tick();
        total++;
        if (lg_a.size() != exp_q.size()) begin
            bad++; $display("FAIL basic_len: got %0d want %0d", lg_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= lg_a.size() || lg_a[i] !== exp_q[i]) begin
                bad++; $display("FAIL basic_byte[%0d]: got %h want %h", i, (i < lg_a.size()) ? lg_a[i] : 8'hxx, exp_q[i]);
            end
        end
        total++; if (q_first(lc_a) != c0 + 1) begin bad++; $display("FAIL basic_latency: got cycle %0d want %0d", q_first(lc_a), c0 + 1); end
        total++; if (q_last(lc_a) != c0 + exp_q.size()) begin bad++; $display("FAIL basic_contig: last wr cycle %0d want %0d", q_last(lc_a), c0 + exp_q.size()); end
        total++; if (ld_a.size() != 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", ld_a.size()); end
        total++; if (q_first(ld_a) != q_last(lc_a) + 1) begin bad++; $display("FAIL basic_done_pos: got cycle %0d want %0d", q_first(ld_a), q_last(lc_a) + 1); end
    endtask

    task automatic test_lowercase();
        int c0;
        clear_logs();
        add_exp("deadbeef", 1'b0);
        value_b = 32'hDEADBEEF; start_b = 1'b1; c0 = cyc;
        tick();
        start_b = 1'b0;
        wait_done(1, 1, 40);
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL lower_busy_end: got %b want 0", busy_b); end
        repeat (3) tick();
        total++;
        if (lg_b.size() != exp_q.size()) begin
            bad++; $display("FAIL lower_len: got %0d want %0d", lg_b.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= lg_b.size() || lg_b[i] !== exp_q[i]) begin
                bad++; $display("FAIL lower_byte[%0d]: got %h want %h", i, (i < lg_b.size()) ? lg_b[i] : 8'hxx, exp_q[i]);
            end
        end
        total++; if (q_last(lc_b) != c0 + exp_q.size()) begin bad++; $display("FAIL lower_contig: last wr cycle %0d want %0d", q_last(lc_b), c0 + exp_q.size()); end
        total++; if (q_first(ld_b) != q_last(lc_b) + 1) begin bad++; $display("FAIL lower_done_pos: got cycle %0d want %0d", q_first(ld_b), q_last(lc_b) + 1); end
    endtask

    task automatic test_backpressure();
        int c0;
        clear_logs();
        add_exp("0000000F", 1'b1);
        value_a = 32'h0000000F; start_a = 1'b1; c0 = cyc;
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (wr_a !== 1'b0) begin bad++; $display("FAIL bp_hold[%0d]: wr got %b want 0", k, wr_a); end
            tick();
        end
        full = 1'b0;
        wait_done(0, 1, 40);
        repeat (2) tick();
        total++;
        if (lg_a.size() != exp_q.size()) begin
            bad++; $display("FAIL bp_len: got %0d want %0d", lg_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= lg_a.size() || lg_a[i] !== exp_q[i]) begin
                bad++; $display("FAIL bp_byte[%0d]: got %h want %h", i, (i < lg_a.size()) ? lg_a[i] : 8'hxx, exp_q[i]);
            end
        end
        total++;
        if (lc_a.size() < 4 || lc_a[2] != c0 + 3 || lc_a[3] != c0 + 9) begin
            bad++; $display("FAIL bp_resume: byte3/4 cycles %0d/%0d want %0d/%0d",
                            (lc_a.size() > 2) ? lc_a[2] : -1, (lc_a.size() > 3) ? lc_a[3] : -1, c0 + 3, c0 + 9);
        end
        total++; if (q_first(ld_a) != c0 + exp_q.size() + 6) begin bad++; $display("FAIL bp_done_pos: got cycle %0d want %0d", q_first(ld_a), c0 + exp_q.size() + 6); end
    endtask

    task automatic test_last_byte_stall();
        int c0;
        int nb;
        clear_logs();
        add_exp("A", 1'b1);
        nb = exp_q.size();
        value_c = 4'hA; start_c = 1'b1; c0 = cyc;
        tick();
        start_c = 1'b0;
        repeat (nb - 1) tick();
        full = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (wr_c !== 1'b0)   begin bad++; $display("FAIL last_hold_wr[%0d]: got %b want 0", k, wr_c); end
            total++; if (done_c !== 1'b0) begin bad++; $display("FAIL last_hold_done[%0d]: got %b want 0", k, done_c); end
            tick();
        end
        full = 1'b0;
        wait_done(2, 1, 10);
        total++; if (busy_c !== 1'b0) begin bad++; $display("FAIL last_busy_end: got %b want 0", busy_c); end
        repeat (2) tick();
        total++;
        if (lg_c.size() != nb) begin
            bad++; $display("FAIL last_len: got %0d want %0d", lg_c.size(), nb);
        end
        for (int i = 0; i < nb; i++) begin
            total++;
            if (i >= lg_c.size() || lg_c[i] !== exp_q[i]) begin
                bad++; $display("FAIL last_byte[%0d]: got %h want %h", i, (i < lg_c.size()) ? lg_c[i] : 8'hxx, exp_q[i]);
            end
        end
        total++; if (q_last(lc_c) != c0 + nb + 2) begin bad++; $display("FAIL last_wr_pos: got cycle %0d want %0d", q_last(lc_c), c0 + nb + 2); end
        total++; if (q_first(ld_c) != c0 + nb + 3) begin bad++; $display("FAIL last_done_pos: got cycle %0d want %0d", q_first(ld_c), c0 + nb + 3); end
    endtask

    task automatic test_back_to_back();
        int n1;
        clear_logs();
        add_exp("12345678", 1'b1);
        n1 = exp_q.size();
        value_a = 32'h12345678; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        value_a = 32'hFFFFFFFF; start_a = 1'b1;
        repeat (3) tick();
        start_a = 1'b0; value_a = '0;
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", busy_a); end
        wait_done(0, 1, 40);
        value_a = 32'h0F1E2D3C; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        add_exp("0F1E2D3C", 1'b1);
        wait_done(0, 2, 40);
        repeat (3) tick();
        total++;
        if (lg_a.size() != exp_q.size()) begin
            bad++; $display("FAIL b2b_len: got %0d want %0d", lg_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= lg_a.size() || lg_a[i] !== exp_q[i]) begin
                bad++; $display("FAIL b2b_byte[%0d]: got %h want %h", i, (i < lg_a.size()) ? lg_a[i] : 8'hxx, exp_q[i]);
            end
        end
        total++;
        if (lc_a.size() <= n1 || ld_a.size() < 1 || lc_a[n1] != ld_a[0] + 1) begin
            bad++; $display("FAIL b2b_restart: second msg first wr cycle %0d want %0d",
                            (lc_a.size() > n1) ? lc_a[n1] : -1, q_first(ld_a) + 1);
        end
        total++; if (ld_a.size() != 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", ld_a.size()); end
    endtask

    task automatic test_reset_mid();
        int c0;
        clear_logs();
        add_exp("89ABCDEF", 1'b1);
        value_a = 32'h89ABCDEF; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        total++; if (wr_a !== 1'b0) begin bad++; $display("FAIL rst_mid_wr: got %b want 0", wr_a); end
        tick();
        reset = 1'b0;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL rst_mid_done: got %b want 0", done_a); end
        repeat (4) tick();
        total++; if (lg_a.size() != 4) begin bad++; $display("FAIL rst_mid_partial: got %0d bytes want 4", lg_a.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= lg_a.size() || lg_a[i] !== exp_q[i]) begin
                bad++; $display("FAIL rst_mid_byte[%0d]: got %h want %h", i, (i < lg_a.size()) ? lg_a[i] : 8'hxx, exp_q[i]);
            end
        end
        total++; if (ld_a.size() != 0) begin bad++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", ld_a.size()); end

        clear_logs();
        add_exp("5A5A0001", 1'b1);
        value_a = 32'h5A5A0001; start_a = 1'b1; c0 = cyc;
        tick();
        start_a = 1'b0;
        wait_done(0, 1, 40);
        repeat (2) tick();
        total++;
        if (lg_a.size() != exp_q.size()) begin
            bad++; $display("FAIL rst_new_len: got %0d want %0d", lg_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= lg_a.size() || lg_a[i] !== exp_q[i]) begin
                bad++; $display("FAIL rst_new_byte[%0d]: got %h want %h", i, (i < lg_a.size()) ? lg_a[i] : 8'hxx, exp_q[i]);
            end
        end
        total++; if (q_first(lc_a) != c0 + 1) begin bad++; $display("FAIL rst_new_latency: got cycle %0d want %0d", q_first(lc_a), c0 + 1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lowercase();
        test_backpressure();
        test_last_byte_stall();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
